fp_decoder: RTL
===============

// Module: fp_decoder
// PURPOSE
//  Expands one 8-bit floating-point code {S, E[2:0], F[3:0]} back into a 12-bit
//  two's-complement linear value D = (S ? -1 : 1) * F * 2^E.
//  Inverse path of the FP_conversion encoder. Multi-cycle: one shift per cycle.
//  Valid/ready on both sides, so it sits between a code source and a linear sink.
// PARAMETERS
//  EXP_W  3   exponent width
//  SIG_W  4   significand width
//  OUT_W  12  output width; must satisfy OUT_W >= SIG_W + 2^EXP_W
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      code on in_s/in_e/in_f is valid
//  in_ready   out  1      decoder can accept a code
//  in_s       in   1      sign bit
//  in_e       in   EXP_W  exponent
//  in_f       in   SIG_W  significand
//  out_valid  out  1      out_d holds a finished result
//  out_ready  in   1      sink accepts out_d
//  out_d      out  OUT_W  two's-complement result
//  out_err    out  1      non-canonical code flag; present only with FP_DECODE_ERR_EN
// BEHAVIOUR
//  Reset:
//   - state=IDLE, acc=0, cnt=0, sign=0, in_ready=1, out_valid=0, out_d=0, out_err=0
//   - rst wins over every other event, mid-shift included; any partial result is discarded
//  FSM: IDLE -> SHIFT -> SIGN -> DONE -> IDLE
//   - IDLE: in_ready=1. When in_valid is high, capture sign<=in_s, cnt<=in_e,
//     acc<={zeros,in_f}; go to SHIFT.
//   - SHIFT: if cnt==0, go to SIGN; else acc<=acc<<1 and cnt<=cnt-1.
//   - SIGN: if sign, acc<=~acc+1 (OUT_W wrap); go to DONE.
//   - DONE: out_valid=1 and out_d=acc. Hold out_d stable while out_ready=0.
//     When out_ready is high, go to IDLE.
//  Handshake:
//   - in_ready=1 only in IDLE, so there is no overlap.
//   - The next code is accepted no earlier than the cycle after the DONE handshake.
//  Latency: out_valid rises E+3 edges after the accept edge. E=0 gives 3; E=7 gives 10.
//  Arithmetic:
//   - No overflow is possible: max |D| = 15*128 = 1920 < 2048.
//   - -0 (S=1, F=0) decodes to 0.
//  Inputs are ignored outside IDLE. out_d reads 0 outside DONE.
// CONFIGURATION
//  FP_DECODE_ERR_EN defined:
//   - out_err port exists. It is latched at accept as (in_e!=0 && in_f[3]==0).
//   - It is valid with out_valid and cleared on return to IDLE.
//   - The value is still decoded normally.
//  FP_DECODE_ERR_EN undefined: out_err port and its logic are absent; all else identical.
// STRUCTURE
//  Package fp_pkg:
//   - EXP_W/SIG_W/OUT_W constants
//   - fp_code_t struct {s,e,f}
//   - dec_state_t enum {IDLE,SHIFT,SIGN,DONE}
//  Sub-module fp_decode_shifter holds acc/cnt load, shift and negate datapath.
//   - Controlled by load/shift/neg strobes from the top-level FSM.
// TESTING
//  1. Code 0_100_1011, out_ready=1 -> out_d=12'h0B0 (176), out_valid 7 edges after accept.
//  2. Code 1_111_1111 -> out_d=12'h880 (-1920); latency 10.
//  3. Code 0_000_0000 and 1_000_0000 -> out_d=12'h000; latency 3; no X on outputs.
//  4. Backpressure: code 0_001_1000, out_ready low 4 cycles after out_valid.
//     -> out_d=12'h010 held stable, in_ready=0; handshake, then in_ready=1 next cycle.
//  5. rst pulsed while in SHIFT (E=6) -> next edge: out_valid=0, in_ready=1, out_d=0.
//     The following code decodes correctly.
//  6. With FP_DECODE_ERR_EN: code 0_010_0101 -> out_d=12'h014, out_err=1.
//     Code 0_010_1101 -> out_err=0.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared widths, code struct and decoder state encoding for the
// floating-point code expander (fp_decoder) and its datapath.
package fp_pkg;

  localparam int unsigned EXP_W = 3;
  localparam int unsigned SIG_W = 4;
  localparam int unsigned OUT_W = 12;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] f;
  } fp_code_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } dec_state_t;

  // A non-zero exponent with a clear significand MSB is not a normalised code.
  function automatic logic is_noncanonical(input fp_code_t c);
    return (c.e != '0) && !c.f[SIG_W-1];
  endfunction

endpackage

// File: rtl/fp_decode_shifter.sv
// fp_decode_shifter: accumulator/counter datapath for fp_decoder.
// Loads the significand and exponent, shifts left one place per strobe while
// counting the exponent down, and negates (two's complement) on request.
module fp_decode_shifter
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic             neg,
  input  logic [EXP_W-1:0] load_e,
  input  logic [SIG_W-1:0] load_f,
  output logic [OUT_W-1:0] acc,
  output logic             cnt_zero
);

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;

  // Next accumulator/counter value; load has priority over shift and negate.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = OUT_W'(load_f);
      cnt_d = load_e;
    end else if (shift) begin
      acc_d = acc_q << 1;
      cnt_d = cnt_q - EXP_W'(1);
    end else if (neg) begin
      acc_d = ~acc_q + OUT_W'(1);
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc      = acc_q;
  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/fp_decoder.sv
// fp_decoder: expands an 8-bit code {S,E,F} into a 12-bit two's-complement
// value (S ? -1 : 1) * F * 2^E, one shift per cycle, valid/ready both sides.
// Optional feature: define FP_DECODE_ERR_EN to add the out_err flag that marks
// non-canonical codes (E != 0 with F MSB clear).
module fp_decoder
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_s,
  input  logic [EXP_W-1:0] in_e,
  input  logic [SIG_W-1:0] in_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_d
`ifdef FP_DECODE_ERR_EN
  ,
  output logic             out_err
`endif
);

  dec_state_t       state_q, state_d;
  logic             sign_q, sign_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_d_q, out_d_d;
  logic             load, shift, neg;
  logic [OUT_W-1:0] acc;
  logic             cnt_zero;
  fp_code_t         code;

`ifdef FP_DECODE_ERR_EN
  logic             err_q, err_d;
`endif

  assign code = '{s: in_s, e: in_e, f: in_f};

  fp_decode_shifter u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .neg      (neg),
    .load_e   (code.e),
    .load_f   (code.f),
    .acc      (acc),
    .cnt_zero (cnt_zero)
  );

  // Next-state, datapath strobes and registered output values.
  // The result is registered on the way out, so out_valid appears one cycle
  // after entering DONE and drops on the handshake edge itself.
  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    out_valid_d = out_valid_q;
    out_d_d     = out_d_q;
    load        = 1'b0;
    shift       = 1'b0;
    neg         = 1'b0;
`ifdef FP_DECODE_ERR_EN
    err_d       = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          sign_d  = code.s;
          state_d = SHIFT;
`ifdef FP_DECODE_ERR_EN
          err_d   = is_noncanonical(code);
`endif
        end
      end
      SHIFT: begin
        if (cnt_zero) state_d = SIGN;
        else          shift   = 1'b1;
      end
      SIGN: begin
        neg     = sign_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          out_d_d     = '0;
          sign_d      = 1'b0;
`ifdef FP_DECODE_ERR_EN
          err_d       = 1'b0;
`endif
        end else begin
          out_valid_d = 1'b1;
          out_d_d     = acc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_d_q     <= '0;
`ifdef FP_DECODE_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      out_valid_q <= out_valid_d;
      out_d_q     <= out_d_d;
`ifdef FP_DECODE_ERR_EN
      err_q       <= err_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign out_d     = out_d_q;
`ifdef FP_DECODE_ERR_EN
  assign out_err   = err_q & out_valid_q;
`endif

endmodule
